// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the ysyx_24100006 NPC.
// This package holds the AXI read-response codes, the fetch fault codes
// that the PC register consumes, and the IFU state encoding.
package ysyx_24100006_pkg;

  // AXI4-Lite read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Fetch fault classification, forwarded to the PC register
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUS      = 2'b10;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'b00,
    IFU_ADDR = 2'b01,
    IFU_DATA = 2'b10,
    IFU_OUT  = 2'b11
  } ifu_state_e;

endpackage

// File: rtl/ysyx_24100006_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// It is intended for latency and performance counters.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (clears the count)
//   clear       : the count becomes 0 at the next edge (clear has priority over enable)
//   enable      : the count goes up by one at the next edge and stops at all-ones
//   count_next  : the value the counter takes at the next edge. Owners that
//                 snapshot the count on the same edge read this output.
module ysyx_24100006_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/ysyx_24100006_ifu_fetch.sv
// Instruction-fetch unit of the multi-cycle NPC.
// The unit latches the pc, issues one AXI4-Lite read on the AR and R channels,
// and hands {pc, inst, fault} to the IDU over a valid/ready handshake.
// Ports:
//   clk, reset              : clock and synchronous active-high reset
//   pc_i, fetch_req         : pc from the PC register and the retire pulse from the WBU
//   araddr/arvalid/arready  : AXI read address channel
//   rdata/rresp/rvalid/rready : AXI read data channel
//   out_valid/out_ready     : handshake to the IDU
//   out_pc/out_inst         : payload to the IDU
//   access_fault            : 00 none, 01 misaligned pc, 10 bus error
//   fetch_cycles            : ADDR+DATA cycle count of the last completed fetch
module ysyx_24100006_ifu_fetch
  import ysyx_24100006_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit RESET_FETCH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              fetch_req,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [1:0]        access_fault,
  output logic [31:0]       fetch_cycles
);

  ifu_state_e        state, state_next;
  logic              pend;
  logic [ADDR_W-1:0] pc_q;
  logic              start;
  logic              misaligned;
  logic [31:0]       cnt_next;

  assign start      = (state == IFU_IDLE) && (fetch_req || pend);
  assign misaligned = (pc_i[1:0] != 2'b00);

  // The latency counter restarts on every fetch and counts only bus-wait cycles.
  ysyx_24100006_sat_counter #(
    .WIDTH (32)
  ) u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .enable     ((state == IFU_ADDR) || (state == IFU_DATA)),
    .count_next (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IFU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IFU_IDLE: begin
        if (start) begin
          state_next = misaligned ? IFU_OUT : IFU_ADDR;
        end
      end
      IFU_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_next = IFU_DATA;
        end
      end
      IFU_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          state_next = IFU_OUT;
        end
      end
      IFU_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IFU_IDLE;
        end
      end
      default: state_next = IFU_IDLE;
    endcase
  end

  // araddr comes from the latched pc, so later changes on pc_i cannot disturb an address in flight.
  assign araddr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend         <= RESET_FETCH;
      pc_q         <= '0;
      out_pc       <= '0;
      out_inst     <= '0;
      access_fault <= FAULT_NONE;
      fetch_cycles <= '0;
    end else begin
      // A request that arrives while busy is remembered once and served from IDLE.
      if (start) begin
        pend <= 1'b0;
      end else if (fetch_req && (state != IFU_IDLE)) begin
        pend <= 1'b1;
      end

      unique case (state)
        IFU_IDLE: begin
          if (start) begin
            pc_q <= pc_i;
            if (misaligned) begin
              out_pc       <= pc_i;
              out_inst     <= '0;
              access_fault <= FAULT_MISALIGN;
              fetch_cycles <= '0;
            end
          end
        end
        IFU_DATA: begin
          if (rvalid) begin
            out_pc       <= pc_q;
            out_inst     <= rdata;
            access_fault <= (rresp != RESP_OKAY) ? FAULT_BUS : FAULT_NONE;
            fetch_cycles <= cnt_next;
          end
        end
        IFU_OUT: begin
          if (out_ready) begin
            access_fault <= FAULT_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
